// File: rtl/axis_fifo_reader.sv
// axis_fifo_reader: turns the read port of a fixed-latency (non-FWFT) synchronous
// FIFO into a registered AXI4-Stream master. Reads are issued ahead, tracked
// through the FIFO read latency, and landed in a small skid buffer so the stream
// side runs at full rate and tolerates backpressure without dropping words.
module axis_fifo_reader #(
    parameter int  DATA_WIDTH   = 8,
    parameter int  READ_LATENCY = 1,
    localparam int BUF_DEPTH    = READ_LATENCY + 1,
    localparam int CNT_W        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [CNT_W-1:0]      occupancy
);
    localparam int               PTR_W    = $clog2(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W:0]   LIMIT    = (CNT_W + 1)'(BUF_DEPTH);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("axis_fifo_reader: DATA_WIDTH must be at least 1");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("axis_fifo_reader: READ_LATENCY must be in 1..4");
    end

    // Buffer depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [READ_LATENCY-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    logic [READ_LATENCY-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic [CNT_W-1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]        infl;
    logic                    pop;
    logic                    wr;

    assign pop  = tvalid_q & m_tready;
    assign wr   = pend_q[READ_LATENCY-1];
    assign infl = popcnt(pend_q);

    // Read issue: stored + in-flight words, less this cycle's pop, must leave room
    // for one more; reset gates the strobe because the FIFO is not yet live.
    always_comb begin
        fifo_rd_en = rst_n & ~fifo_empty &
                     (({1'b0, cnt_q} + {1'b0, infl}) < (LIMIT + (CNT_W + 1)'(pop)));
    end

    // In-flight shift register: bit 0 records this cycle's read, the top bit marks
    // the cycle its data appears on fifo_dout.
    always_comb begin
        // NOTE: assign a default to every always_comb output first so no path can infer a latch.
        pend_d    = '0;
        pend_d[0] = fifo_rd_en;
        for (int i = 1; i < READ_LATENCY; i++) pend_d[i] = pend_q[i-1];
    end

    // Buffer bookkeeping and the next registered head word.
    always_comb begin
        wr_ptr_d = wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(wr) - CNT_W'(pop);
        tvalid_d = (cnt_d != '0);
        occ_d    = cnt_d + popcnt(pend_d);
        // Empty buffer keeps the last word on the bus; a word landing in the slot
        // that becomes the head is forwarded straight from the FIFO.
        tdata_d  = tdata_q;
        if (cnt_d != '0) begin
            tdata_d = (wr && (wr_ptr_q == rd_ptr_d)) ? fifo_dout : mem_q[rd_ptr_d];
        end
    end

    // Buffer storage: written whenever a returned word arrives.
    // NOTE: storage is not reset; cnt_q and the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= fifo_dout;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            pend_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            occ_q    <= occ_d;
        end
    end

    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_axis_fifo_reader.sv
// tb_axis_fifo_reader: one lane per READ_LATENCY (1..4), each with its own
// fixed-latency FIFO model, running directed scenarios then a random soak.
// A per-lane monitor scoreboards every delivered word, bounds occupancy and
// checks AXIS hold-while-stalled.
module tb_axis_fifo_reader;
    localparam int DW    = 16;
    localparam int MEM_N = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_lat
        localparam int RL = gi + 1;
        localparam int D  = RL + 1;
        localparam int CW = $clog2(D + 1);

        logic          rst_n;
        logic          rd_en;
        logic          fifo_empty;
        logic          force_empty;
        logic [DW-1:0] dout;
        logic [DW-1:0] tdata;
        logic          tvalid;
        logic          tready;
        logic [CW-1:0] occ;
        logic          done_l = 1'b0;

        logic [DW-1:0] mem  [MEM_N];
        logic [DW-1:0] pipe [RL];
        int            rd_idx  = 0;
        int            avail   = 0;
        int            exp_idx = 0;
        logic          stall_q = 1'b0;
        logic [DW-1:0] stall_data;

        assign fifo_empty = force_empty | (rd_idx >= avail);
        assign dout       = pipe[RL-1];

        axis_fifo_reader #(.DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .fifo_rd_en (rd_en),
            .fifo_empty (fifo_empty),
            .fifo_dout  (dout),
            .m_tdata    (tdata),
            .m_tvalid   (tvalid),
            .m_tready   (tready),
            .occupancy  (occ)
        );

        function automatic string tg(input string s);
            return $sformatf("L%0d %s", RL, s);
        endfunction

        task automatic push(input logic [DW-1:0] v);
            mem[avail[13:0]] = v;
            avail++;
        endtask

        task automatic drain();
            int c;
            c = 0;
            tready = 1'b1;
            force_empty = 1'b0;
            while ((exp_idx != avail || occ != '0) && c < 300) begin
                cyc();
                #1;
                c++;
            end
            check(tg("drain words delivered"), 32'(exp_idx), 32'(avail));
            check(tg("drain occupancy"), 32'(occ), 32'd0);
        endtask

        // FIFO model: fixed read latency, output pipeline cleared with the system reset.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < RL; k++) pipe[k] <= '0;
            end else begin
                if (rd_en) begin
                    check(tg("read while empty"), 32'(fifo_empty), 32'd0);
                    rd_idx <= rd_idx + 1;
                end
                pipe[0] <= mem[rd_idx[13:0]];
                for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
            end
        end

        // Stream monitor: order scoreboard, occupancy bound, AXIS stability.
        always @(negedge clk) begin
            if (!rst_n) begin
                exp_idx <= rd_idx;
                stall_q <= 1'b0;
            end else begin
                check(tg("occupancy bound"), 32'(occ <= CW'(D)), 32'd1);
                if (stall_q) begin
                    check(tg("stall tvalid hold"), 32'(tvalid), 32'd1);
                    check(tg("stall tdata hold"), 32'(tdata), 32'(stall_data));
                end
                if (tvalid && tready) begin
                    check(tg("word was read"), 32'(exp_idx < rd_idx), 32'd1);
                    check(tg("word order"), 32'(tdata), 32'(mem[exp_idx[13:0]]));
                    exp_idx <= exp_idx + 1;
                end
                stall_q    <= tvalid & ~tready;
                stall_data <= tdata;
            end
        end

        initial begin
            int rd_cnt, rd_first, rd_last, v_cnt, v_first, v_last, pops, run, base;
            logic [DW-1:0] held;

            // Reset: outputs zero and no read strobe even with data available.
            rst_n = 1'b0;
            tready = 1'b1;
            force_empty = 1'b0;
            cyc();
            cyc();
            push(16'h00A5);
            #1;
            check(tg("reset rd_en"), 32'(rd_en), 32'd0);
            check(tg("reset tvalid"), 32'(tvalid), 32'd0);
            check(tg("reset tdata"), 32'(tdata), 32'd0);
            check(tg("reset occupancy"), 32'(occ), 32'd0);

            // Single word: read at t, visible for one cycle at t+RL+1.
            rst_n = 1'b1;
            #1;
            check(tg("single issue"), 32'(rd_en), 32'd1);
            check(tg("single occ t"), 32'(occ), 32'd0);
            for (int k = 1; k <= RL + 2; k++) begin
                cyc();
                #1;
                check(tg("single rd_en"), 32'(rd_en), 32'd0);
                check(tg("single tvalid"), 32'(tvalid), 32'(k == RL + 1));
                check(tg("single tdata"), 32'(tdata), (k >= RL + 1) ? 32'h00A5 : 32'h0);
                check(tg("single occupancy"), 32'(occ), (k <= RL + 1) ? 32'd1 : 32'd0);
            end

            // Streaming 0..63 at full rate.
            for (int i = 0; i < 64; i++) push(DW'(i));
            #1;
            rd_cnt = 0; rd_first = -1; rd_last = -1;
            v_cnt = 0; v_first = -1; v_last = -1;
            for (int c = 0; c < 120; c++) begin
                if (rd_en) begin
                    rd_cnt++;
                    if (rd_first < 0) rd_first = c;
                    rd_last = c;
                end
                if (tvalid) begin
                    v_cnt++;
                    if (v_first < 0) v_first = c;
                    v_last = c;
                end
                cyc();
                #1;
            end
            check(tg("stream reads"), 32'(rd_cnt), 32'd64);
            check(tg("stream reads first"), 32'(rd_first), 32'd0);
            check(tg("stream reads span"), 32'(rd_last - rd_first + 1), 32'd64);
            check(tg("stream valids"), 32'(v_cnt), 32'd64);
            check(tg("stream first valid"), 32'(v_first), 32'(RL + 1));
            check(tg("stream valid span"), 32'(v_last - v_first + 1), 32'd64);

            // Backpressure: 10 stall cycles mid-stream, then gapless resume.
            drain();
            for (int i = 0; i < 40; i++) push(DW'(16'h0100 + i));
            #1;
            pops = 0;
            for (int c = 0; c < 10; c++) begin
                if (tvalid && tready) pops++;
                cyc();
                #1;
            end
            check(tg("bp pops before stall"), 32'(pops), 32'(9 - RL));
            tready = 1'b0;
            #1;
            held = tdata;
            for (int k = 0; k < 10; k++) begin
                check(tg("bp occupancy"), 32'(occ), 32'(D));
                check(tg("bp rd_en"), 32'(rd_en), 32'd0);
                check(tg("bp tvalid"), 32'(tvalid), 32'd1);
                check(tg("bp tdata"), 32'(tdata), 32'(held));
                cyc();
                #1;
            end
            tready = 1'b1;
            #1;
            check(tg("bp restart same cycle"), 32'(rd_en), 32'd1);
            run = 0;
            while (tvalid && run < 100) begin
                run++;
                cyc();
                #1;
            end
            check(tg("bp gapless run"), 32'(run), 32'(40 - pops));

            // FIFO empties with two reads in flight.
            drain();
            base = avail;
            for (int i = 0; i < 20; i++) push(DW'(16'h0200 + i));
            #1;
            check(tg("mt read 0"), 32'(rd_en), 32'd1);
            cyc();
            #1;
            check(tg("mt read 1"), 32'(rd_en), 32'd1);
            cyc();
            force_empty = 1'b1;
            #1;
            for (int k = 0; k < 8; k++) begin
                check(tg("mt rd_en low"), 32'(rd_en), 32'd0);
                cyc();
                #1;
            end
            check(tg("mt in-flight delivered"), 32'(exp_idx - base), 32'd2);
            check(tg("mt occupancy"), 32'(occ), 32'd0);
            force_empty = 1'b0;
            #1;
            check(tg("mt resume"), 32'(rd_en), 32'd1);
            drain();

            // Asynchronous reset with the buffer full.
            tready = 1'b0;
            for (int i = 0; i < 20; i++) push(DW'(16'h0300 + i));
            for (int k = 0; k < 8; k++) cyc();
            #1;
            check(tg("pre-reset occupancy"), 32'(occ), 32'(D));
            rst_n = 1'b0;
            #1;
            check(tg("async rst tvalid"), 32'(tvalid), 32'd0);
            check(tg("async rst tdata"), 32'(tdata), 32'd0);
            check(tg("async rst occupancy"), 32'(occ), 32'd0);
            check(tg("async rst rd_en"), 32'(rd_en), 32'd0);
            avail = rd_idx;
            tready = 1'b1;
            cyc();
            cyc();
            rst_n = 1'b1;
            for (int k = 0; k < 8; k++) begin
                cyc();
                #1;
                check(tg("post-reset tvalid"), 32'(tvalid), 32'd0);
                check(tg("post-reset occupancy"), 32'(occ), 32'd0);
            end

            // Random soak.
            for (int c = 0; c < 10000; c++) begin
                cyc();
                tready = ($urandom_range(0, 99) < 70);
                force_empty = ($urandom_range(0, 99) < 25);
                if ((avail - rd_idx) < 6 && avail < MEM_N - 8) push(DW'($urandom));
            end
            drain();
            done_l = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 40000 && !all_done; c++) begin
            @(posedge clk);
            all_done = g_lat[0].done_l & g_lat[1].done_l & g_lat[2].done_l & g_lat[3].done_l;
        end
        check("all lanes finished", 32'(all_done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
